// File: rtl/div_unit.sv
// Multi-cycle RV32M divide/remainder unit that stalls the core FSM in EXECUTE.
// Radix-2 restoring division, one quotient bit per cycle, with single-cycle special cases.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            div_busy,
  output logic            div_done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FIXUP = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [CW-1:0]   cnt;
  logic [XLEN:0]   rem;
  logic [XLEN-1:0] quot;
  logic [XLEN-1:0] divisor;
  logic            rem_sel;
  logic            neg_q;
  logic            neg_r;

  logic            accept;
  logic            is_signed;
  logic            is_rem;
  logic            div_by_zero;
  logic            overflow;
  logic            special;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic [XLEN-1:0] special_res;
  logic [XLEN+1:0] rem_shift;
  logic [XLEN+1:0] trial;

  // Operand decode for the request being accepted this cycle.
  always_comb begin
    accept      = (state == IDLE) && start;
    is_signed   = ~op[0];
    is_rem      = op[1];
    abs_a       = (is_signed && rs1[XLEN-1]) ? -rs1 : rs1;
    abs_b       = (is_signed && rs2[XLEN-1]) ? -rs2 : rs2;
    div_by_zero = (rs2 == '0);
    overflow    = is_signed && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    special     = div_by_zero || overflow;
    if (div_by_zero) begin
      special_res = is_rem ? rs1 : '1;
    end else begin
      special_res = is_rem ? '0 : rs1;
    end
  end

  // One restoring step: the extra top bit of trial is the borrow/sign.
  always_comb begin
    rem_shift = {rem, quot[XLEN-1]};
    trial     = rem_shift - {2'b00, divisor};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = special ? DONE : RUN;
      RUN:     if (cnt == CW'(XLEN - 1)) state_nxt = FIXUP;
      FIXUP:   state_nxt = DONE;
      DONE:    if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gated by reset so the FSM never sees a stall request while the unit is held in reset.
  assign div_busy = reset_n && (accept || (state == RUN) || (state == FIXUP));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      div_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      div_done <= (state_nxt == DONE);
    end
  end

  // The result register only changes on a special-case accept or in FIXUP, never mid-iteration.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      rem     <= '0;
      quot    <= '0;
      divisor <= '0;
      rem_sel <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rem_sel <= is_rem;
            divisor <= abs_b;
            quot    <= abs_a;
            rem     <= '0;
            cnt     <= '0;
            neg_q   <= is_signed && (rs1[XLEN-1] ^ rs2[XLEN-1]);
            neg_r   <= is_signed && rs1[XLEN-1];
            if (special) begin
              result <= special_res;
            end
          end
        end
        RUN: begin
          if (trial[XLEN+1]) begin
            rem <= rem_shift[XLEN:0];
          end else begin
            rem <= trial[XLEN:0];
          end
          quot <= {quot[XLEN-2:0], ~trial[XLEN+1]};
          cnt  <= cnt + CW'(1);
        end
        FIXUP: begin
          if (rem_sel) begin
            result <= neg_r ? -rem[XLEN-1:0] : rem[XLEN-1:0];
          end else begin
            result <= neg_q ? -quot : quot;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M cases plus randomized ops
// compared against an arithmetic reference model.
module tb_div_unit;

  localparam int XLEN = 32;
  localparam logic [31:0] MIN_INT = 32'h8000_0000;
  localparam logic [31:0] ALL_ONE = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        div_busy;
  logic        div_done;
  logic [31:0] result;

  int checkCount = 0;
  int failCount  = 0;

  div_unit #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .rs1      (rs1),
    .rs2      (rs2),
    .div_busy (div_busy),
    .div_done (div_done),
    .result   (result)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic bit isSpecial(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!o[0] && a == MIN_INT && b == ALL_ONE);
  endfunction

  // RISC-V M-extension semantics from plain arithmetic.
  function automatic logic [31:0] refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] sr;
    sa = a;
    sb = b;
    if (b == 32'd0) return o[1] ? a : ALL_ONE;
    if (!o[0] && a == MIN_INT && b == ALL_ONE) return o[1] ? 32'd0 : MIN_INT;
    case (o)
      2'd0:    sr = sa / sb;
      2'd1:    sr = a / b;
      2'd2:    sr = sa % sb;
      default: sr = a % b;
    endcase
    return sr;
  endfunction

  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                               input int holdCycles, input bit dropEarly);
    logic [31:0] expRes;
    int          expBusy;
    int          busyCycles;
    int          budget;
    expRes  = refModel(o, a, b);
    expBusy = isSpecial(o, a, b) ? 1 : XLEN + 2;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    rs1   = a;
    rs2   = b;
    #1 checkOutput("busy_on_start", 32'(div_busy), 32'd1);
    @(posedge clk);
    #1;
    rs1 = $urandom;
    rs2 = $urandom;
    op  = 2'($urandom_range(0, 3));
    busyCycles = 1;
    budget     = 0;
    while (budget < 100) begin
      @(negedge clk);
      budget++;
      if (dropEarly && budget == 3) start = 1'b0;
      if (!div_busy) break;
      busyCycles++;
    end
    checkOutput("busy_len", 32'(busyCycles), 32'(expBusy));
    checkOutput("done", 32'(div_done), 32'd1);
    checkOutput("result", result, expRes);
    if (!dropEarly) begin
      repeat (holdCycles) begin
        @(negedge clk);
        checkOutput("hold_busy", 32'(div_busy), 32'd0);
        checkOutput("hold_done", 32'(div_done), 32'd1);
        checkOutput("hold_result", result, expRes);
      end
      start = 1'b0;
    end
    @(negedge clk);
    checkOutput("idle_done", 32'(div_done), 32'd0);
    checkOutput("idle_busy", 32'(div_busy), 32'd0);
    checkOutput("idle_result", result, expRes);
  endtask

  function automatic logic [31:0] pickOperand(input int kind);
    case (kind)
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 50));
      2:       return 32'(-$urandom_range(1, 50));
      default: begin
        case ($urandom_range(0, 3))
          0:       return 32'd0;
          1:       return MIN_INT;
          2:       return ALL_ONE;
          default: return 32'd1;
        endcase
      end
    endcase
  endfunction

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    op      = 2'd0;
    rs1     = '0;
    rs2     = '0;
    #12;
    checkOutput("reset_busy", 32'(div_busy), 32'd0);
    checkOutput("reset_done", 32'(div_done), 32'd0);
    checkOutput("reset_result", result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    applyStimulus(2'd1, 32'd100, 32'd7, 0, 1'b0);
    applyStimulus(2'd3, 32'd100, 32'd7, 0, 1'b0);
    applyStimulus(2'd0, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    applyStimulus(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    applyStimulus(2'd0, 32'd7, 32'hFFFF_FFFE, 0, 1'b0);
    applyStimulus(2'd1, 32'd5, 32'd0, 0, 1'b0);
    applyStimulus(2'd2, 32'h8000_0005, 32'd0, 0, 1'b0);
    applyStimulus(2'd0, MIN_INT, ALL_ONE, 0, 1'b0);
    applyStimulus(2'd2, MIN_INT, ALL_ONE, 0, 1'b0);
    applyStimulus(2'd1, MIN_INT, ALL_ONE, 0, 1'b0);
    applyStimulus(2'd1, 32'd1000, 32'd33, 3, 1'b0);
    applyStimulus(2'd1, 32'd9, 32'd3, 0, 1'b0);
    applyStimulus(2'd0, 32'hFFFF_FF00, 32'd17, 0, 1'b1);

    // Reset in the middle of an iteration, with start still high.
    @(negedge clk);
    start = 1'b1;
    op    = 2'd1;
    rs1   = 32'd12345;
    rs2   = 32'd7;
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midrun_reset_busy", 32'(div_busy), 32'd0);
    checkOutput("midrun_reset_done", 32'(div_done), 32'd0);
    checkOutput("midrun_reset_result", result, 32'd0);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(2'd3, 32'd12345, 32'd7, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      rop = 2'($urandom_range(0, 3));
      ra  = pickOperand($urandom_range(0, 3));
      rb  = pickOperand($urandom_range(0, 3));
      applyStimulus(rop, ra, rb, $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle RV32M divide/remainder unit that sits directly upstream of the core control FSM and drives its `div_busy` input. Started by the datapath while the FSM is in EXECUTE, it holds `div_busy` high until the result is ready, so the FSM stalls in EXECUTE and then advances to WRITE_BACK. It uses a radix-2 restoring algorithm (one quotient bit per cycle) with single-cycle handling of the RISC-V special cases.

## Interface
Parameters:
- `XLEN`, 32, operand and result width; the counter width is $clog2(XLEN)+1.

Ports:
- `clk`  in  1  core clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level request; high while the FSM is in EXECUTE with a DIV/DIVU/REM/REMU instruction.
- `op`  in  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled when the start is accepted.
- `rs1`  in  XLEN  dividend; sampled when the start is accepted.
- `rs2`  in  XLEN  divisor; sampled when the start is accepted.
- `div_busy`  out  1  combinational; high while the FSM must stay in EXECUTE.
- `div_done`  out  1  registered; high while in DONE (result valid).
- `result`  out  XLEN  registered quotient or remainder; held until the next accepted start.

## Operation
- States:
  - IDLE: waits for a start.
  - RUN: iterates; the counter counts 0..XLEN-1.
  - FIXUP: applies sign correction and loads `result`.
  - DONE: holds the result until `start` drops.
- IDLE with `start`=1 accepts the request:
  - Latch `op`.
  - Latch the magnitudes of rs1/rs2. Signed ops take two's-complement abs; unsigned ops use the raw values.
  - Latch `neg_q` = rs1[31]^rs2[31] (signed ops only) and `neg_r` = rs1[31] (signed ops only).
  - Clear the 33-bit partial remainder, load the quotient shift register with |rs1|, and clear the counter.
  - Next state is RUN, unless a special case applies (below).
- Special cases, resolved in IDLE; next state is DONE and `result` is loaded directly:
  - rs2 == 0, DIV/DIVU: `result` = all ones.
  - rs2 == 0, REM/REMU: `result` = rs1.
  - DIV with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF: `result` = 0x80000000.
  - REM with the same operands: `result` = 0.
- RUN, each cycle:
  - Shift {rem, quot} left by 1.
  - trial = rem_shifted − |rs2| (33-bit).
  - If trial is non-negative: rem = trial and quot[0] = 1. Otherwise rem is kept and quot[0] = 0.
  - Increment the counter. After the XLEN-th iteration, go to FIXUP.
- FIXUP:
  - DIV/DIVU: `result` = neg_q ? −quot : quot.
  - REM/REMU: `result` = neg_r ? −rem[31:0] : rem[31:0].
  - Next state is DONE.
- DONE:
  - `div_busy`=0 and `div_done`=1.
  - Go to IDLE when `start`=0. While `start` stays high, stay in DONE and accept no new operation. This keeps the lingering level `start` from re-triggering during WRITE_BACK.
- `div_busy` = (IDLE & start) | RUN | FIXUP. It is never high in DONE.
- Input changes on `op`/`rs1`/`rs2` after acceptance are ignored.

## Timing
- Reset (asynchronous assert, any state, including mid-RUN):
  - State goes to IDLE; counter, quot, rem and `result` go to 0.
  - `div_busy`=0 and `div_done`=0 immediately.
  - No partial result is ever exposed.
- Normal op, with the start accepted in cycle 0:
  - `div_busy` is high in cycles 0..XLEN+1 (cycles 0..33 for XLEN=32).
  - RUN occupies cycles 1..32 and FIXUP cycle 33.
  - In cycle 34, DONE has `div_busy`=0, `div_done`=1 and `result` valid.
  - Total stall is 34 cycles.
- Special case: `div_busy` is high only in cycle 0; in cycle 1 the state is DONE with `result` valid.
- `div_busy` rises in the same cycle as `start`, combinationally from IDLE, so the FSM never leaves EXECUTE early.
- `start` falling in DONE returns the unit to IDLE on the next edge.
- A new `start` can be accepted no earlier than one cycle after IDLE is re-entered.
- `start` deasserting during RUN/FIXUP does not abort the operation; it completes and sits in DONE with `start`=0, then returns to IDLE the next cycle.

## Test plan
- DIVU 100/7: `div_busy` high for 34 cycles, then `result`=14 with `div_done`=1. REMU 100/7 gives `result`=2.
- DIV −7/2 gives `result`=0xFFFFFFFD (−3). REM −7/2 gives 0xFFFFFFFF (−1). DIV 7/−2 gives 0xFFFFFFFD.
- Divide by zero:
  - DIVU 5/0 gives 0xFFFFFFFF; REM 0x80000005/0 gives 0x80000005.
  - In both cases `div_busy` is high for exactly 1 cycle.
- Overflow: DIV 0x80000000/0xFFFFFFFF gives 0x80000000 and REM gives 0, with a 1-cycle busy. DIVU on the same operands gives 0 after 34 cycles.
- Level-start hold:
  - Keep `start`=1 for 3 cycles after `div_done`; there is no second busy pulse and `result` is unchanged.
  - Drop `start`, then re-start with 9/3; the unit returns `result`=3.
- Reset mid-RUN: deassert `reset_n` at cycle 10 of a DIVU. `div_busy`, `div_done` and `result` go to 0 asynchronously, and a new op after release completes correctly.
